// File: rtl/sw_alloc_rr_if.sv
// Switch-allocator bundle: per-input crossbar requests in, grants and
// per-output crossbar selects out.
interface sw_alloc_rr_if #(
    parameter int NUM_PORTS = 5,
    parameter int PORT_W    = 3
);
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS*PORT_W-1:0] req_port;
    logic [NUM_PORTS*3-1:0]      req_flit_type;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS*PORT_W-1:0] xbar_sel;
    logic [NUM_PORTS-1:0]        xbar_valid;
    logic [NUM_PORTS-1:0]        out_locked;
    logic                        illegal_req;

    modport master (
        output req, req_port, req_flit_type, out_ready,
        input  grant, xbar_sel, xbar_valid, out_locked, illegal_req
    );

    modport slave (
        input  req, req_port, req_flit_type, out_ready,
        output grant, xbar_sel, xbar_valid, out_locked, illegal_req
    );
endinterface

// File: rtl/sw_alloc_rr.sv
// Round-robin switch allocator with per-output packet locking: an output stays
// bound to one input from its head flit until its tail flit is granted.
module sw_alloc_rr #(
    parameter int         NUM_PORTS = 5,
    parameter int         PORT_W    = 3,
    parameter logic [2:0] TAIL_TYPE = 3'b010
) (
    input  logic         clk,
    input  logic         rst,
    sw_alloc_rr_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

    lock_t             lock   [NUM_PORTS];
    logic [PORT_W-1:0] owner  [NUM_PORTS];
    logic [PORT_W-1:0] rr_ptr [NUM_PORTS];
    logic              illegal_q;

    logic [PORT_W-1:0]           win_idx [NUM_PORTS];
    logic [NUM_PORTS-1:0]        win_tail;
    logic [NUM_PORTS-1:0]        grant_c;
    logic [NUM_PORTS-1:0]        valid_c;
    logic [NUM_PORTS*PORT_W-1:0] sel_c;
    logic                        illegal_seen;

    // Zero-latency arbitration: a locked output only considers its owner,
    // an idle output scans inputs starting just after the last winner.
    always_comb begin
        int   idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        grant_c  = '0;
        valid_c  = '0;
        sel_c    = '0;
        win_tail = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            win_idx[o] = '0;
            found      = 1'b0;
            if (!rst && bus.out_ready[o]) begin
                if (lock[o] == LOCKED) begin
                    if (bus.req[owner[o]] &&
                        bus.req_port[owner[o]*PORT_W +: PORT_W] == PORT_W'(o)) begin
                        found      = 1'b1;
                        win_idx[o] = owner[o];
                    end
                end else begin
                    for (int k = 1; k <= NUM_PORTS; k++) begin
                        idx = int'(rr_ptr[o]) + k;
                        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
                        if (!found && bus.req[idx] &&
                            bus.req_port[idx*PORT_W +: PORT_W] == PORT_W'(o)) begin
                            found      = 1'b1;
                            win_idx[o] = PORT_W'(idx);
                        end
                    end
                end
            end
            if (found) begin
                grant_c[win_idx[o]]          = 1'b1;
                valid_c[o]                   = 1'b1;
                sel_c[o*PORT_W +: PORT_W]    = win_idx[o];
                win_tail[o] = (bus.req_flit_type[win_idx[o]*3 +: 3] == TAIL_TYPE);
            end
        end
    end

    always_comb begin
        illegal_seen = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (bus.req[i] && int'(bus.req_port[i*PORT_W +: PORT_W]) >= NUM_PORTS)
                illegal_seen = 1'b1;
        end
    end

    // Lock state only moves on a granted flit; backpressure and bubbles hold it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock[o]   <= IDLE;
                owner[o]  <= '0;
                rr_ptr[o] <= PORT_W'(NUM_PORTS - 1);
            end
            illegal_q <= 1'b0;
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (valid_c[o]) begin
                    rr_ptr[o] <= win_idx[o];
                    if (lock[o] == LOCKED) begin
                        if (win_tail[o]) lock[o] <= IDLE;
                    end else if (!win_tail[o]) begin
                        lock[o]  <= LOCKED;
                        owner[o] <= win_idx[o];
                    end
                end
            end
            if (illegal_seen) illegal_q <= 1'b1;
        end
    end

    always_comb begin
        bus.out_locked = '0;
        for (int o = 0; o < NUM_PORTS; o++) bus.out_locked[o] = (lock[o] == LOCKED);
    end

    assign bus.grant       = grant_c;
    assign bus.xbar_valid  = valid_c;
    assign bus.xbar_sel    = sel_c;
    assign bus.illegal_req = illegal_q;

endmodule

// File: doc/sw_alloc_rr.md
Name: sw_alloc_rr

Overview:
- Switch allocator for the router crossbar. Arbitrates per-input crossbar requests (one per input buffer's cba_request) for each output port using round-robin.
- Holds an output locked to one input from the first granted non-tail flit until that input's tail flit is granted, so packets never interleave on an output.
- Drives each input buffer's cba_grant and the crossbar's per-output input-select.

Parameters:
- NUM_PORTS, 5, number of router input ports and output ports (L, N, E, S, W).
- PORT_W, 3, width of a port index; must satisfy 2^PORT_W >= NUM_PORTS.
- TAIL_TYPE, 3'b010, flit-type code (flit bits [57:55]) marking a tail flit.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_PORTS  per-input crossbar request (buffer cba_request).
- req_port  in  NUM_PORTS*PORT_W  per-input requested output index; slice i = [i*PORT_W +: PORT_W].
- req_flit_type  in  NUM_PORTS*3  per-input flit-type bits [57:55] of the head-of-queue flit.
- out_ready  in  NUM_PORTS  per-output downstream can accept a flit this cycle.
- grant  out  NUM_PORTS  per-input one-cycle grant (buffer cba_grant); the buffer dequeues in the same cycle.
- xbar_sel  out  NUM_PORTS*PORT_W  per-output index of the input routed this cycle.
- xbar_valid  out  NUM_PORTS  per-output: a flit crosses this cycle.
- out_locked  out  NUM_PORTS  per-output: registered lock state.
- illegal_req  out  1  sticky flag: some req with req_port >= NUM_PORTS was seen.

Behaviour:
- Per-output registered state:
  - lock: 0 = IDLE, 1 = LOCKED.
  - owner: PORT_W bits.
  - rr_ptr: PORT_W bits, the last winner.
- Reset values:
  - lock = 0, owner = 0, rr_ptr = NUM_PORTS-1, so input 0 has first priority.
  - illegal_req = 0.
  - While rst is high, grant, xbar_valid and xbar_sel are forced to 0.
- Grant path is combinational from req / req_port / req_flit_type / out_ready and the registered state. There are 0 cycles from request to grant.
- Candidate set for output o: inputs i with req[i]=1 and req_port slice i == o.
- Output o in IDLE:
  - If out_ready[o]=1 and the candidate set is non-empty, the winner is the first candidate scanning i = rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS.
  - Assert grant[winner], xbar_valid[o]=1, xbar_sel[o]=winner.
  - Next cycle: rr_ptr <= winner.
  - If the granted flit type != TAIL_TYPE: lock <= 1, owner <= winner. Otherwise stay IDLE, so a single-flit packet is allowed.
- Output o in LOCKED:
  - Only owner is eligible. Other candidates receive no grant and do not move rr_ptr.
  - Grant when req[owner]=1, req_port[owner]==o and out_ready[o]=1.
  - If the granted flit type == TAIL_TYPE, lock <= 0 next cycle. The output is arbitrated again in the cycle after the tail, never in the tail's own cycle.
  - If the owner does not request (bubble) or out_ready=0, hold the lock and issue no grant.
- out_ready[o]=0: no grant on o; lock, owner and rr_ptr are unchanged.
- Because each input names one output, at most one grant per input per cycle. Each output has at most one xbar_valid.
- Inactive outputs: xbar_sel = 0 when xbar_valid = 0.
- req_port >= NUM_PORTS:
  - The request matches no output and is never granted.
  - illegal_req sets the next cycle and clears only on rst.
- Simultaneous candidates on one output: exactly one grant, chosen by rr order. The losers hold req and are served in later cycles in rr order, so no starvation.
- Reset asserted mid-packet: all locks clear immediately (asynchronous). After release, arbitration restarts from input 0 priority.
- req_flit_type is sampled only in a granted cycle.

Test Plan:
- Single flit: rst release; req=5'b00001, req_port0=2, type=TAIL_TYPE, out_ready=all 1 -> grant=5'b00001 same cycle, xbar_sel[2]=0, xbar_valid[2]=1; out_locked[2]=0 next cycle.
- Round-robin: inputs 1, 3, 4 all request output 0 with TAIL_TYPE for 4 cycles -> grants go to 1, 3, 4, 1 in successive cycles; xbar_sel[0] follows 1, 3, 4, 1.
- Packet lock: input 2 sends head (000), body (001), tail (010) to output 4 while input 0 also requests output 4 -> input 2 granted 3 consecutive cycles, out_locked[4]=1 after the head; input 0 granted the cycle after the tail.
- Backpressure and bubble in lock: during the packet above, out_ready[4]=0 for 2 cycles, then input 2 deasserts req for 1 cycle -> no grants in those cycles, out_locked[4] stays 1, and the tail still completes the packet afterwards.
- Parallel outputs plus illegal request: input 0 -> out 1, input 1 -> out 0, input 3 req_port=6, all in the same cycle -> grant=5'b00011, xbar_sel[1]=0, xbar_sel[0]=1, illegal_req=1 from the next cycle until rst.
- Reset mid-packet: assert rst after the head flit on output 3 -> out_locked=0 and grant=0 immediately; after release, a different input's head to output 3 is granted the first cycle.
